// File: rtl/fixed_point_widening_stage.sv
// Qm.n -> wide accumulator format expander, 2-stage valid/ready pipeline.
// Optional saturation event counter: define WIDEN_SAT_COUNT_EN.
module fixed_point_widening_stage #(
    parameter int IN_WIDTH   = 16,
    parameter int IN_FRAC    = 15,
    parameter int ACC_WIDTH  = 42,
    parameter int ACC_FRAC   = 32,
    parameter int GAIN_SHIFT = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [IN_WIDTH-1:0]  data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic [ACC_WIDTH-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 sat_sticky,
    output logic [CNT_WIDTH-1:0] sat_count
);

    localparam int FRAC_DIFF = ACC_FRAC - IN_FRAC;
    localparam int SH        = FRAC_DIFF + GAIN_SHIFT;
    localparam int EXT_W     = IN_WIDTH + SH;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    if (ACC_FRAC < IN_FRAC) begin : g_chk_frac
        $error("ACC_FRAC must be >= IN_FRAC");
    end
    if (GAIN_SHIFT < 0 || GAIN_SHIFT > ACC_WIDTH - 1) begin : g_chk_gain
        $error("GAIN_SHIFT out of range 0..ACC_WIDTH-1");
    end

    logic                 r_s1_valid;
    logic [IN_WIDTH-1:0]  r_s1_data;
    logic                 r_s2_valid;
    logic [ACC_WIDTH-1:0] r_data_out;
    logic                 r_ovf;
    logic                 r_unf;
    logic                 r_sticky;

    logic                 w_adv1;
    logic                 w_adv2;
    logic                 w_flush;
    logic                 w_load_clip;
    logic signed [EXT_W-1:0] w_ext;
    logic [ACC_WIDTH-1:0] w_res;
    logic                 w_ovf;
    logic                 w_unf;

    assign w_adv2    = !r_s2_valid || ready_in;
    assign w_adv1    = !r_s1_valid || w_adv2;
    assign w_flush   = !rst_n || clear;
    assign ready_out = w_adv1;

    // Exact product: sign-extend to full width, then shift in zero LSBs.
    assign w_ext = EXT_W'(signed'(r_s1_data)) <<< SH;

    if (EXT_W > ACC_WIDTH) begin : g_clip
        logic [EXT_W-ACC_WIDTH:0] w_hi;
        assign w_hi  = w_ext[EXT_W-1:ACC_WIDTH-1];
        assign w_ovf = ~w_ext[EXT_W-1] & (|w_hi);
        assign w_unf = w_ext[EXT_W-1] & ~(&w_hi);
        assign w_res = w_ovf ? ACC_MAX :
                       w_unf ? ACC_MIN : w_ext[ACC_WIDTH-1:0];
    end else begin : g_noclip
        assign w_ovf = 1'b0;
        assign w_unf = 1'b0;
        assign w_res = ACC_WIDTH'(w_ext);
    end

    assign w_load_clip = w_adv2 && r_s1_valid && (w_ovf || w_unf);

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= valid_in;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv1 && valid_in) begin
            r_s1_data <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_s2_valid <= 1'b0;
            r_data_out <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            r_data_out <= r_s1_valid ? w_res : '0;
            r_ovf      <= r_s1_valid && w_ovf;
            r_unf      <= r_s1_valid && w_unf;
        end
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_sticky <= 1'b0;
        end else if (w_load_clip) begin
            r_sticky <= 1'b1;
        end
    end

`ifdef WIDEN_SAT_COUNT_EN
    logic [CNT_WIDTH-1:0] r_sat_count;

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_sat_count <= '0;
        end else if (w_load_clip && r_sat_count != '1) begin
            r_sat_count <= r_sat_count + 1'b1;
        end
    end

    assign sat_count = r_sat_count;
`else
    assign sat_count = '0;
`endif

    assign data_out   = r_data_out;
    assign valid_out  = r_s2_valid;
    assign overflow   = r_ovf;
    assign underflow  = r_unf;
    assign sat_sticky = r_sticky;

endmodule

// File: doc/fixed_point_widening_stage.md
Name: fixed_point_widening_stage

Overview:
- Front-end format expander for the CIC decimator/accumulator chain: converts narrow signed Qm.n samples (default Q1.15) into the wide accumulator format (default 42-bit, 32 fractional bits).
- Optional power-of-two gain pre-scale with saturation.
- 2-stage registered pipeline with valid/ready backpressure, per-sample clip flags and sticky status.
- Performs the inverse of the back-end rounding/saturation stage, so both ends of the chain share one fixed-point convention.

Parameters:
- IN_WIDTH, 16, input sample width, signed.
- IN_FRAC, 15, input fractional bits.
- ACC_WIDTH, 42, output width, signed.
- ACC_FRAC, 32, output fractional bits. Must satisfy ACC_FRAC >= IN_FRAC; elaboration fails with $error otherwise.
- GAIN_SHIFT, 0, extra left shift applied after alignment. Range 0..ACC_WIDTH-1.
- CNT_WIDTH, 16, width of the saturation event counter.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: synchronous active-low reset.
- clear, in, 1: synchronous flush. Empties the pipeline and clears status. Pipeline contents and status only, not a full reset.
- data_in, in, IN_WIDTH: signed input sample.
- valid_in, in, 1: data_in is valid.
- ready_out, out, 1: stage can accept a sample this cycle.
- data_out, out, ACC_WIDTH: signed widened sample.
- valid_out, out, 1: data_out is valid.
- ready_in, in, 1: downstream accepts data_out.
- overflow, out, 1: positive clip on the current data_out. Qualified by valid_out.
- underflow, out, 1: negative clip on the current data_out. Qualified by valid_out.
- sat_sticky, out, 1: set by any clip. Cleared only by reset or clear.
- sat_count, out, CNT_WIDTH: count of clipped samples (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk edge) drives all of the following to 0: data_out, valid_out, overflow, underflow, sat_sticky, sat_count, and both stage valid bits.
- ready_out is combinational, so it reads 1 while the pipeline is empty.
- Reset mid-operation discards in-flight samples with no partial outputs.
- Constants:
  - FRAC_DIFF = ACC_FRAC - IN_FRAC.
  - SH = FRAC_DIFF + GAIN_SHIFT.
- Arithmetic: exact value v = sext(data_in) * 2^SH, computed at width IN_WIDTH+SH.
  - If v > 2^(ACC_WIDTH-1)-1: data_out = ACC_MAX, overflow = 1.
  - If v < -2^(ACC_WIDTH-1): data_out = ACC_MIN, underflow = 1.
  - Otherwise data_out = v[ACC_WIDTH-1:0], both flags 0.
  - Vacated LSBs are zero.
  - If IN_WIDTH+SH <= ACC_WIDTH, clipping is impossible and flags stay 0.
- Pipeline:
  - S1 registers data_in.
  - S2 registers the shifted/saturated result and flags (drives the outputs).
  - Latency: 2 clk from input handshake to valid_out with no stall.
  - Throughput: 1 sample/clk.
- Handshake:
  - Input transfer when valid_in && ready_out.
  - Output transfer when valid_out && ready_in.
  - adv2 = !valid_out || ready_in.
  - adv1 = !s1_valid || adv2.
  - ready_out = adv1 (combinational, no dependency on valid_in).
- Stall: when adv2=0, data_out, flags and valid_out are held stable. S1 holds its sample, and ready_out drops once S1 is full.
- No bubble insertion: a full pipeline with ready_in=1 and valid_in=1 moves every cycle.
- Status:
  - sat_sticky sets on the cycle a clipped sample is loaded into S2.
  - clear and rst_n have the same effect on status and valid bits. clear does not reset data registers.
  - clear has priority over a simultaneous input transfer; that sample is dropped.
- Output data and flags are 0 whenever valid_out = 0. S2 loads zeros on flush/empty advance.

Optional Feature:
- Macro: WIDEN_SAT_COUNT_EN.
- Defined:
  - sat_count increments by 1 on each clipped sample loaded into S2.
  - Saturates at 2^CNT_WIDTH-1, no wrap.
  - Cleared by rst_n or clear.
- Undefined: sat_count is tied to 0 and no counter logic is synthesized. All other behaviour is identical.

Test Plan:
- Defaults, 0x4000 then 0x8000 back-to-back with ready_in=1:
  - Outputs 0x00080000000 then 0x3FF00000000.
  - 2 clk latency, flags 0.
- GAIN_SHIFT=10:
  - 0x3FFF -> 0x1FFF8000000, no flag.
  - 0x4000 -> 0x1FFFFFFFFFF, overflow=1.
  - 0xC000 -> 0x20000000000, no flag.
  - 0xBFFF -> 0x20000000000, underflow=1.
  - sat_sticky=1 after the first clip.
- Backpressure: stream 0x0001..0x0008 while ready_in follows the pattern 1,0,0,1,0,1...:
  - All 8 outputs appear in order (0x0001<<17 ... 0x0008<<17), no loss or duplication.
  - data_out is stable during stalls.
  - ready_out=0 only while both stages are full and ready_in=0.
- Reset/clear mid-stream: assert rst_n=0 (then separately clear=1) with 2 samples in flight:
  - Next cycle valid_out=0, sat_sticky=0, sat_count=0.
  - The sample presented with clear is dropped.
- WIDEN_SAT_COUNT_EN, CNT_WIDTH=2, GAIN_SHIFT=10, five 0x7FFF samples:
  - sat_count reads 1,2,3,3,3.
  - Without the macro it stays 0.
